// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK transmit/receive frame format.
// csum8 must stay identical to the receiver's checksum so frames validate end to end.
package qpsk_pkg;

   localparam int unsigned FRAME_W       = 56;
   localparam int unsigned PAY_W         = 40;
   localparam int unsigned SYM_PER_FRAME = 28;
   localparam logic [7:0]  HEADER_DEF    = 8'hcc;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_SEND
   } tx_state_e;

   // Sum of the payload bytes, carries dropped.
   function automatic logic [7:0] csum8(input logic [PAY_W-1:0] payload);
      logic [7:0] s;
      s = '0;
      for (int unsigned i = 0; i < PAY_W / 8; i++) begin
         s = s + payload[i*8 +: 8];
      end
      return s;
   endfunction

endpackage

// File: rtl/qpsk_sym_timer.sv
// Free-running symbol-period counter; bnd_o marks the last clock of every symbol period.
module qpsk_sym_timer #(
   parameter int unsigned SAMPLE = 100
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic bnd_o
);

   localparam int unsigned CNT_W = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign bnd_o = (cnt_q == CNT_W'(SAMPLE - 1));

   always_comb begin
      cnt_d = bnd_o ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/qpsk_frame_tx.sv
// QPSK transmit framer: captures a payload, appends header/checksum and shifts the
// frame out as I/Q bit pairs, one pair per symbol period aligned to the symbol timer.
module qpsk_frame_tx
   import qpsk_pkg::*;
#(
   parameter logic [7:0]  HEADER = HEADER_DEF,
   parameter int unsigned SAMPLE = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PAY_W-1:0]  data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              sym_i,
   output logic              sym_q,
   output logic              sym_stb,
   output logic              tx_busy,
   output logic              frame_done
);

   tx_state_e          state_q, state_d;
   logic [FRAME_W-1:0] sr_q, sr_d;
   logic [4:0]         left_q, left_d;
   logic [1:0]         pair_q, pair_d;
   logic               stb_q, stb_d;
   logic               done_q, done_d;
   logic               bnd;

   qpsk_sym_timer #(
      .SAMPLE(SAMPLE)
   ) u_timer (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bnd_o (bnd)
   );

   assign data_ready = (state_q == ST_IDLE);
   assign tx_busy    = (state_q != ST_IDLE);
   assign sym_i      = pair_q[1];
   assign sym_q      = pair_q[0];
   assign sym_stb    = stb_q;
   assign frame_done = done_q;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      left_d  = left_q;
      pair_d  = pair_q;
      stb_d   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pair_d = '0;
            if (data_valid) begin
               sr_d    = {HEADER, data_in, csum8(data_in)};
               left_d  = 5'(SYM_PER_FRAME - 1);
               state_d = ST_ARMED;
            end
         end
         // Waits for the next boundary even if accepted on one, keeping symbols aligned.
         ST_ARMED: begin
            if (bnd) begin
               pair_d  = sr_q[FRAME_W-1 -: 2];
               sr_d    = {sr_q[FRAME_W-3:0], 2'b00};
               stb_d   = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bnd) begin
               if (left_q == '0) begin
                  pair_d  = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  pair_d = sr_q[FRAME_W-1 -: 2];
                  sr_d   = {sr_q[FRAME_W-3:0], 2'b00};
                  left_d = left_q - 1'b1;
                  stb_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         left_q  <= '0;
         pair_q  <= '0;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         left_q  <= left_d;
         pair_q  <= pair_d;
         stb_q   <= stb_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_qpsk_frame_tx.sv
// Scoreboard bench for qpsk_frame_tx at SAMPLE=4: frames reassembled from the I/Q
// stream are compared with frames built from each accepted payload.
module tb_qpsk_frame_tx;

   localparam int SAMPLE = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [39:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic        sym_i;
   logic        sym_q;
   logic        sym_stb;
   logic        tx_busy;
   logic        frame_done;

   qpsk_frame_tx #(
      .HEADER(8'hcc),
      .SAMPLE(SAMPLE)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .sym_i     (sym_i),
      .sym_q     (sym_q),
      .sym_stb   (sym_stb),
      .tx_busy   (tx_busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [55:0] model_frame(input logic [39:0] p);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 5; i++) s = s + p[8*i +: 8];
      return {8'hcc, p, s};
   endfunction

   // scoreboard: push on accepted handshake
   logic [55:0] exp_q[$];
   int          n_acc = 0;

   always @(posedge clk) begin
      if (rst_n && data_valid && data_ready) begin
         exp_q.push_back(model_frame(data_in));
         n_acc++;
      end
   end

   // monitor
   int          cyc = 0;
   int          n_sym = 0;
   int          last_stb = 0;
   int          first_stb = 0;
   int          last_done = -1;
   logic [55:0] cur = '0;
   logic [55:0] last_frame = '0;
   logic [55:0] e;
   logic [1:0]  held = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         check("rst_outputs", {59'd0, sym_i, sym_q, sym_stb, tx_busy, frame_done}, 64'd0);
         n_sym     = 0;
         last_done = -1;
      end else begin
         check("rdy_vs_busy", data_ready, !tx_busy);
         check("stb_done_excl", sym_stb & frame_done, 0);
         if (sym_stb) begin
            check("stb_busy", tx_busy, 1);
            if (n_sym == 0) begin
               first_stb = cyc;
               if (last_done >= 0) check("gap_ge_sym", (cyc - last_done) >= SAMPLE, 1);
            end else begin
               check("stb_spacing", cyc - last_stb, SAMPLE);
            end
            last_stb = cyc;
            held     = {sym_i, sym_q};
            cur      = {cur[53:0], held};
            n_sym++;
         end else if (frame_done) begin
            check("done_sym00", {sym_i, sym_q}, 0);
            check("done_nsym", n_sym, 28);
            check("done_len", cyc - first_stb, 28 * SAMPLE);
            check("done_idle", tx_busy, 0);
            check("sb_has_exp", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("frame", cur, e);
            end
            last_frame = cur;
            n_sym      = 0;
            last_done  = cyc;
         end else if (n_sym > 0) begin
            check("sym_hold", {sym_i, sym_q}, held);
         end else begin
            check("idle_sym00", {sym_i, sym_q}, 0);
         end
      end
   end

   task automatic wait_acc(input int target);
      int t = 0;
      while (n_acc < target && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("acc_timeout", n_acc >= target, 1);
   endtask

   task automatic wait_frame_done();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!frame_done && t < 2000);
      check("done_timeout", frame_done, 1);
   endtask

   task automatic send(input logic [39:0] d);
      int tgt;
      tgt        = n_acc + 1;
      data_in    = d;
      data_valid = 1'b1;
      wait_acc(tgt);
      data_valid = 1'b0;
      data_in    = {8'($urandom), $urandom};
   endtask

   task automatic first_stb_latency(output int lat);
      @(negedge clk);
      data_valid = 1'b0;
      lat = 1;
      while (!sym_stb && lat < 50) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int          base;
      int          lat;
      int          t;
      logic [39:0] d6;

      rst_n      = 1'b0;
      data_valid = 1'b0;
      data_in    = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", data_ready, 1);
      check("rst_busy", tx_busy, 0);

      // single frame, known checksum
      send(40'h0102030405);
      wait_frame_done();
      @(negedge clk);
      check("t1_frame", last_frame, 56'hcc01020304050f);

      // checksum wraps
      send(40'hffffffffff);
      wait_frame_done();
      @(negedge clk);
      check("t2_frame", last_frame, 56'hccfffffffffffb);

      // valid held high across three frames, data changed after each acceptance
      base       = n_acc;
      data_in    = 40'h1122334455;
      data_valid = 1'b1;
      wait_acc(base + 1);
      data_in = 40'ha5a55a5a00;
      wait_acc(base + 2);
      data_in = 40'h0f1e2d3c4b;
      wait_acc(base + 3);
      data_in = {8'($urandom), $urandom};
      wait_frame_done();
      check("t3_acc_count", n_acc, base + 3);

      // accept in the cycle after a boundary (cnt==0)
      data_in    = 40'hdeadbeef01;
      data_valid = 1'b1;
      first_stb_latency(lat);
      check("lat_cnt0", lat, SAMPLE);
      wait_frame_done();

      // accept on a boundary cycle
      repeat (SAMPLE - 1) @(negedge clk);
      data_in    = 40'h0000000080;
      data_valid = 1'b1;
      first_stb_latency(lat);
      check("lat_bnd", lat, SAMPLE + 1);
      wait_frame_done();
      @(negedge clk);

      // reset in the middle of a frame
      send(40'h5555aaaa33);
      t = 0;
      while (t < 10) begin
         @(negedge clk);
         if (sym_stb) t++;
      end
      #2 rst_n = 1'b0;
      #1 check("async_rst", {59'd0, sym_i, sym_q, sym_stb, tx_busy, frame_done}, 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_ready", data_ready, 1);
      d6 = 40'h13579bdf24;
      send(d6);
      wait_frame_done();
      @(negedge clk);
      check("t5_frame", last_frame, model_frame(d6));

      repeat (2) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
